// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle main control unit for the RV32 datapath.
// Sequences fetch, decode, execute, memory and writeback for R-type, LOAD,
// STORE and BRANCH, and produces ula_op for the ula_control block.
// Optional feature macro: MAIN_CONTROL_ILLEGAL_TRAP_EN. When it is defined,
// unsupported opcodes lock the FSM in TRAP until reset. When it is undefined,
// they retire as NOPs.
// Outputs are Moore-decoded from the state register. The exception is
// ir_write/pc_write in FETCH, which wait for mem_ready. Outputs are
// combinational so that rst can force them low in the cycle it rises.
module main_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       ula_src_a,
  output logic [1:0] ula_src_b,
  output logic [1:0] ula_op,
  output logic       retire,
  output logic       illegal_inst
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEM_ADDR = 4'd2;
  localparam logic [3:0] MEM_RD   = 4'd3;
  localparam logic [3:0] MEM_WB   = 4'd4;
  localparam logic [3:0] MEM_WR   = 4'd5;
  localparam logic [3:0] EXEC_R   = 4'd6;
  localparam logic [3:0] ALU_WB   = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] TRAP     = 4'd9;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [3:0] state_r;
  logic [3:0] next_state_s;

  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic [1:0] pc_source_s;
  logic       i_or_d_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic       mem_to_reg_s;
  logic       ula_src_a_s;
  logic [1:0] ula_src_b_s;
  logic [1:0] ula_op_s;
  logic       retire_s;
  logic       illegal_s;

  // State register: rst overrides every state, including held memory states and TRAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: opcode is only consulted in DECODE and MEM_ADDR.
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH: begin
        if (mem_ready) next_state_s = DECODE;
        else           next_state_s = FETCH;
      end
      DECODE: begin
        if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) next_state_s = MEM_ADDR;
        else if (opcode == OPC_R)                          next_state_s = EXEC_R;
        else if (opcode == OPC_BRANCH)                     next_state_s = BRANCH;
`ifdef MAIN_CONTROL_ILLEGAL_TRAP_EN
        else                                               next_state_s = TRAP;
`else
        else                                               next_state_s = FETCH;
`endif
      end
      MEM_ADDR: begin
        if (opcode == OPC_LOAD)       next_state_s = MEM_RD;
        else if (opcode == OPC_STORE) next_state_s = MEM_WR;
        else                          next_state_s = FETCH;
      end
      MEM_RD: begin
        if (mem_ready) next_state_s = MEM_WB;
        else           next_state_s = MEM_RD;
      end
      MEM_WB: next_state_s = FETCH;
      MEM_WR: begin
        if (mem_ready) next_state_s = FETCH;
        else           next_state_s = MEM_WR;
      end
      EXEC_R: next_state_s = ALU_WB;
      ALU_WB: next_state_s = FETCH;
      BRANCH: next_state_s = FETCH;
`ifdef MAIN_CONTROL_ILLEGAL_TRAP_EN
      TRAP:   next_state_s = TRAP;
`endif
      default: next_state_s = FETCH;
    endcase
  end

  // Moore output decode; anything not set for a state stays 0.
  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    pc_source_s     = 2'b00;
    i_or_d_s        = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_write_s     = 1'b0;
    mem_to_reg_s    = 1'b0;
    ula_src_a_s     = 1'b0;
    ula_src_b_s     = 2'b00;
    ula_op_s        = 2'b00;
    retire_s        = 1'b0;
    illegal_s       = 1'b0;
    case (state_r)
      FETCH: begin
        mem_read_s  = 1'b1;
        ula_src_b_s = 2'b01;
        if (mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
        end else begin
          ir_write_s = 1'b0;
          pc_write_s = 1'b0;
        end
      end
      DECODE: begin
        ula_src_b_s = 2'b11;
`ifndef MAIN_CONTROL_ILLEGAL_TRAP_EN
        // Unsupported opcodes complete here as a NOP.
        if ((opcode == OPC_LOAD) || (opcode == OPC_STORE) ||
            (opcode == OPC_R) || (opcode == OPC_BRANCH)) begin
          retire_s = 1'b0;
        end else begin
          retire_s = 1'b1;
        end
`endif
      end
      MEM_ADDR: begin
        ula_src_a_s = 1'b1;
        ula_src_b_s = 2'b10;
      end
      MEM_RD: begin
        mem_read_s = 1'b1;
        i_or_d_s   = 1'b1;
      end
      MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        retire_s     = 1'b1;
      end
      MEM_WR: begin
        mem_write_s = 1'b1;
        i_or_d_s    = 1'b1;
        if (mem_ready) retire_s = 1'b1;
        else           retire_s = 1'b0;
      end
      EXEC_R: begin
        ula_src_a_s = 1'b1;
        ula_op_s    = 2'b10;
      end
      ALU_WB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
      end
      BRANCH: begin
        ula_src_a_s     = 1'b1;
        ula_op_s        = 2'b01;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 2'b01;
        retire_s        = 1'b1;
      end
`ifdef MAIN_CONTROL_ILLEGAL_TRAP_EN
      TRAP: illegal_s = 1'b1;
`endif
      default: illegal_s = 1'b0;
    endcase
  end

  // rst forces every output low in the same cycle, including the FETCH strobes.
  assign pc_write      = pc_write_s      & ~rst;
  assign pc_write_cond = pc_write_cond_s & ~rst;
  assign pc_source     = rst ? 2'b00 : pc_source_s;
  assign i_or_d        = i_or_d_s        & ~rst;
  assign mem_read      = mem_read_s      & ~rst;
  assign mem_write     = mem_write_s     & ~rst;
  assign ir_write      = ir_write_s      & ~rst;
  assign reg_write     = reg_write_s     & ~rst;
  assign mem_to_reg    = mem_to_reg_s    & ~rst;
  assign ula_src_a     = ula_src_a_s     & ~rst;
  assign ula_src_b     = rst ? 2'b00 : ula_src_b_s;
  assign ula_op        = rst ? 2'b00 : ula_op_s;
  assign retire        = retire_s        & ~rst;
`ifdef MAIN_CONTROL_ILLEGAL_TRAP_EN
  assign illegal_inst  = illegal_s       & ~rst;
`else
  assign illegal_inst  = 1'b0;
`endif

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle main control unit for the RV32 datapath. It drives `ula_op` into `ula_control` (the producer side of that interface) and sequences fetch, decode, execute, memory and writeback. Supported opcodes are R-type (0110011), LOAD (0000011), STORE (0100011) and BRANCH (1100011). The memory side uses a single-signal ready handshake.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: inst[6:0] from the datapath instruction register; the same field that forms `ula_control`'s `inst[16:10]`.
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if ALU zero.
- `pc_source` out 2: 00 ALU result, 01 ALU-out register.
- `i_or_d` out 1: memory address select; 0 = PC, 1 = ALU-out.
- `mem_read` out 1, `mem_write` out 1: memory strobes.
- `ir_write` out 1: instruction register load.
- `reg_write` out 1: register file write.
- `mem_to_reg` out 1: writeback select; 1 = memory data.
- `ula_src_a` out 1: ALU A select; 0 = PC, 1 = rs1.
- `ula_src_b` out 2: ALU B select; 00 rs2, 01 const 4, 10 imm, 11 branch imm.
- `ula_op` out 2: 00 add, 01 sub (compare), 10 funct-decoded; 11 is never driven.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `illegal_inst` out 1: high in TRAP (only with the macro defined).

## Operation
- 4-bit state register with states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, ALU_WB, BRANCH, TRAP.
- Outputs are decoded from the state (Moore), except that `ir_write` and `pc_write` in FETCH are gated by `mem_ready`.
- Any output not listed for a state is 0.
- FETCH: `mem_read`=1, `i_or_d`=0, `ula_src_a`=0, `ula_src_b`=01, `ula_op`=00, `pc_source`=00.
  - If `mem_ready`=1: `ir_write`=1, `pc_write`=1, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: `ula_src_a`=0, `ula_src_b`=11, `ula_op`=00. Next state by `opcode`:
  - LOAD or STORE -> MEM_ADDR.
  - R-type -> EXEC_R.
  - BRANCH -> BRANCH.
  - Other opcodes: see Configuration.
- MEM_ADDR: `ula_src_a`=1, `ula_src_b`=10, `ula_op`=00. Next state MEM_RD for LOAD, MEM_WR for STORE.
- MEM_RD: `mem_read`=1, `i_or_d`=1. Go to MEM_WB on `mem_ready`, otherwise hold.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `retire`=1. Next state FETCH.
- MEM_WR: `mem_write`=1, `i_or_d`=1. On `mem_ready`: `retire`=1, next state FETCH; otherwise hold.
- EXEC_R: `ula_src_a`=1, `ula_src_b`=00, `ula_op`=10. Next state ALU_WB.
- ALU_WB: `reg_write`=1, `mem_to_reg`=0, `retire`=1. Next state FETCH.
- BRANCH: `ula_src_a`=1, `ula_src_b`=00, `ula_op`=01, `pc_write_cond`=1, `pc_source`=01, `retire`=1. Next state FETCH.
- Unreachable state encodings go to FETCH on the next edge.

## Timing
- Reset:
  - While `rst`=1, all outputs are forced to 0, including the FETCH strobes.
  - The first edge with `rst`=1 loads FETCH.
  - The first fetch begins in the first cycle after `rst` falls.
- Reset mid-operation: `rst` overrides every state, including a held MEM_RD, MEM_WR or TRAP. Strobes drop in the same cycle `rst` rises.
- Latency with `mem_ready` held high:
  - R-type: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Each cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- Memory handshake:
  - A strobe stays high and stable until the cycle in which `mem_ready`=1.
  - The transfer completes in that cycle.
  - `mem_ready` is ignored in all other states.
- `opcode` is sampled only in DECODE and MEM_ADDR. It must be stable from the cycle after `ir_write` onward.
- `retire` is high for exactly one cycle per instruction, in the final state. It is never asserted during stalls.

## Configuration
- Macro: `MAIN_CONTROL_ILLEGAL_TRAP_EN`.
- Defined:
  - An unsupported opcode in DECODE goes to TRAP.
  - TRAP: `illegal_inst`=1, all other outputs 0, `retire` not asserted.
  - TRAP is held until `rst`.
- Not defined:
  - An unsupported opcode in DECODE goes to FETCH and pulses `retire` in DECODE, so the instruction is treated as a NOP (2 cycles).
  - `illegal_inst` is tied to 0.

## Test plan
- Reset and R-type:
  - Stimulus: hold `rst` for 2 cycles, then `mem_ready`=1, `opcode`=0110011.
  - Required: all outputs 0 during reset.
  - Required: `ula_op` sequence 00, 00, 10, then 00 in FETCH; `reg_write`=1 in cycle 4; `retire` in cycle 4 only.
- LOAD with stalls:
  - Stimulus: `opcode`=0000011, `mem_ready` low for 2 cycles in MEM_RD.
  - Required: `mem_read`=1 and `i_or_d`=1 held for 3 cycles.
  - Required: MEM_WB with `mem_to_reg`=1; 7 cycles total.
- STORE:
  - Stimulus: `opcode`=0100011, `mem_ready` low for 1 cycle in FETCH.
  - Required: `ir_write` and `pc_write` only in the second FETCH cycle; `mem_write` for 1 cycle; `retire` in MEM_WR.
- BRANCH:
  - Stimulus: `opcode`=1100011.
  - Required: in cycle 3, `ula_op`=01, `pc_write_cond`=1, `pc_source`=01; back in FETCH at cycle 4.
- Illegal opcode:
  - Stimulus: `opcode`=1111111.
  - Required with the macro: TRAP with `illegal_inst`=1 held; `rst` returns the FSM to FETCH.
  - Required without the macro: back to FETCH after DECODE, with `retire`=1 in DECODE.
- Reset mid-MEM_RD:
  - Stimulus: assert `rst` while stalled in MEM_RD.
  - Required: `mem_read` drops in the same cycle; FETCH after `rst` is released.
